// File: rtl/cram_backup_if.sv
// cram_backup_if
//   Bundles the SD sector-buffer handshake (HPS side) and the cart RAM
//   backup port that cram_backup sits between.
//
//   SD side:
//     sd_lba        sector number being requested
//     sd_rd/sd_wr   sector read / write request
//     sd_ack        HPS acknowledge, high for the whole sector transfer
//     sd_buff_addr  word index within the current sector
//     sd_buff_wr    HPS is writing sd_buff_dout
//     sd_buff_dout  data from SD
//     sd_buff_din   data to SD
//   Cart RAM backup side:
//     bk_addr       cart RAM word address
//     bk_wr         cart RAM write strobe
//     bk_data       cart RAM write data
//     bk_q          cart RAM read data
//
//   master: the save/load controller.  slave: the HPS / cart RAM side.
interface cram_backup_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_dout;
  logic [15:0] sd_buff_din;
  logic [15:0] bk_addr;
  logic        bk_wr;
  logic [15:0] bk_data;
  logic [15:0] bk_q;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, bk_addr, bk_wr, bk_data,
    input  sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout, bk_q
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, bk_addr, bk_wr, bk_data,
    output sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout, bk_q
  );
endinterface

// File: rtl/cram_backup.sv
// cram_backup
//   Battery-backed cartridge RAM save/load controller. Streams 512-byte
//   (256-word) sectors of the save image into cart RAM after a ROM
//   download, and back out to SD on manual save or autosave when the OSD
//   opens. Transfers always start at sector 0 and run up to last_lba,
//   which is derived from the cartridge header RAM size (or MBC2).
//
//   Ports:
//     clk_sys        system clock, rising edge
//     reset          synchronous, active-high
//     downloading    ROM download in progress
//     img_mounted    one-cycle pulse, save image mounted
//     img_readonly   mounted image is read-only
//     img_size_nz    mounted image has non-zero size
//     mbc_battery    cartridge has a battery
//     mbc2           cartridge is MBC2 (512x4 internal RAM)
//     cart_ram_size  header byte 0x149
//     cram_wr        CPU write strobe to cart RAM
//     osd_status     OSD menu open
//     autosave_en    autosave on OSD open
//     load_req       manual load, acts on rising edge
//     save_req       manual save, acts on rising edge
//     bus            SD sector buffer + cart RAM backup port (master)
//     busy           transfer in progress
//     loading        current or last transfer is a load
module cram_backup (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          downloading,
  input  logic          img_mounted,
  input  logic          img_readonly,
  input  logic          img_size_nz,
  input  logic          mbc_battery,
  input  logic          mbc2,
  input  logic [7:0]    cart_ram_size,
  input  logic          cram_wr,
  input  logic          osd_status,
  input  logic          autosave_en,
  input  logic          load_req,
  input  logic          save_req,
  cram_backup_if.master bus,
  output logic          busy,
  output logic          loading
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic       dl_q;
  logic       dl_rise;
  logic       dl_fall;

  logic       bk_ena;
  logic       sav_supported;
  logic       new_load;
  logic       sav_pending;

  logic       load_src;
  logic       save_src;
  logic       load_src_q;
  logic       save_src_q;
  logic       load_trig;
  logic       save_trig;

  logic       ack_q;
  logic       ack_qq;
  logic       ack_rise;
  logic       ack_fall;

  logic [7:0] lba;
  logic [7:0] lba_nx;
  logic [7:0] last_lba;
  logic       rd_q;
  logic       rd_nx;
  logic       wr_q;
  logic       wr_nx;
  logic       loading_q;
  logic       loading_nx;
  logic       enter_req;

  assign dl_rise = downloading & ~dl_q;
  assign dl_fall = ~downloading & dl_q;

  assign sav_supported = mbc_battery & ((cart_ram_size != 8'd0) | mbc2) & bk_ena;

  // Trigger sources are edge-detected against their previous value every
  // cycle, even while busy, so an edge that lands during a transfer is
  // consumed and never replayed once the controller returns to idle.
  assign load_src  = load_req | new_load;
  assign save_src  = save_req | (sav_pending & osd_status & autosave_en);
  assign load_trig = load_src & ~load_src_q;
  assign save_trig = save_src & ~save_src_q;

  // sd_ack is registered once before edge detection, which adds one cycle
  // of latency between the HPS handshake and the request lines.
  assign ack_rise = ack_q & ~ack_qq;
  assign ack_fall = ~ack_q & ack_qq;

  // Highest sector index for the cart RAM size; MBC2 fits in two sectors.
  always_comb begin
    last_lba = 8'd255;
    if (mbc2) begin
      last_lba = 8'd1;
    end else begin
      case (cart_ram_size)
        8'd1:    last_lba = 8'd3;
        8'd2:    last_lba = 8'd15;
        8'd3:    last_lba = 8'd63;
        default: last_lba = 8'd255;
      endcase
    end
  end

  // Edge-detect history registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q       <= 1'b0;
      load_src_q <= 1'b0;
      save_src_q <= 1'b0;
      ack_q      <= 1'b0;
      ack_qq     <= 1'b0;
    end else begin
      dl_q       <= downloading;
      load_src_q <= load_src;
      save_src_q <= save_src;
      ack_q      <= bus.sd_ack;
      ack_qq     <= ack_q;
    end
  end

  // Enable and request flags. In each flag the set condition is tested
  // first so it wins over a clear in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bk_ena      <= 1'b0;
      new_load    <= 1'b0;
      sav_pending <= 1'b0;
    end else begin
      if (downloading & img_mounted & ~img_readonly) begin
        bk_ena <= 1'b1;
      end else if (dl_rise) begin
        bk_ena <= 1'b0;
      end

      if (dl_fall & sav_supported & img_size_nz) begin
        new_load <= 1'b1;
      end else if (enter_req) begin
        new_load <= 1'b0;
      end

      if (cram_wr & ~osd_status & sav_supported) begin
        sav_pending <= 1'b1;
      end else if (enter_req) begin
        sav_pending <= 1'b0;
      end
    end
  end

  // Transfer FSM next-state. A transfer walks sectors 0..last_lba, each
  // one a REQ (request raised, waiting for ack) followed by XFER (ack held
  // by the HPS while it moves the 256 words).
  always_comb begin
    state_nx   = state;
    lba_nx     = lba;
    rd_nx      = rd_q;
    wr_nx      = wr_q;
    loading_nx = loading_q;
    enter_req  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bk_ena && (load_trig || save_trig)) begin
          state_nx   = ST_REQ;
          enter_req  = 1'b1;
          lba_nx     = 8'd0;
          loading_nx = load_trig;
          rd_nx      = load_trig;
          wr_nx      = ~load_trig;
        end
      end

      ST_REQ: begin
        if (ack_rise) begin
          rd_nx    = 1'b0;
          wr_nx    = 1'b0;
          state_nx = ST_XFER;
        end
      end

      ST_XFER: begin
        if (ack_fall) begin
          if (lba >= last_lba) begin
            state_nx = ST_IDLE;
          end else begin
            lba_nx    = lba + 8'd1;
            rd_nx     = loading_q;
            wr_nx     = ~loading_q;
            state_nx  = ST_REQ;
            enter_req = 1'b1;
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
        rd_nx    = 1'b0;
        wr_nx    = 1'b0;
      end
    endcase
  end

  // Transfer FSM registers. Reset abandons any sector in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      lba       <= 8'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
    end else begin
      state     <= state_nx;
      lba       <= lba_nx;
      rd_q      <= rd_nx;
      wr_q      <= wr_nx;
      loading_q <= loading_nx;
    end
  end

  assign busy    = (state != ST_IDLE);
  assign loading = loading_q;

  assign bus.sd_lba      = {24'h000000, lba};
  assign bus.sd_rd       = rd_q;
  assign bus.sd_wr       = wr_q;

  // Data path is purely combinational; the one-cycle cart RAM read
  // latency is absorbed by the HPS.
  assign bus.sd_buff_din = bus.bk_q;
  assign bus.bk_addr     = {lba, bus.sd_buff_addr};
  assign bus.bk_wr       = bus.sd_buff_wr & bus.sd_ack & loading_q;
  assign bus.bk_data     = bus.sd_buff_dout;

endmodule

// File: tb/tb_cram_backup.sv
// tb_cram_backup
//   Self-checking bench for cram_backup. A small HPS model answers sector
//   requests; each test pushes the sectors it expects (index + direction)
//   onto a scoreboard queue and the HPS model pops and compares them as
//   the controller raises sd_rd/sd_wr. Cart RAM data-path expectations go
//   through a second queue.
module tb_cram_backup;

  typedef struct packed {
    logic       is_load;
    logic [7:0] lba;
  } sector_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } bk_exp_t;

  logic       clk_sys;
  logic       reset;
  logic       downloading;
  logic       img_mounted;
  logic       img_readonly;
  logic       img_size_nz;
  logic       mbc_battery;
  logic       mbc2;
  logic [7:0] cart_ram_size;
  logic       cram_wr;
  logic       osd_status;
  logic       autosave_en;
  logic       load_req;
  logic       save_req;
  logic       busy;
  logic       loading;

  cram_backup_if bus ();

  sector_t sb[$];
  bk_exp_t dq[$];

  int checks;
  int passed;
  int rd_pulses;
  int wr_pulses;

  cram_backup dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .downloading   (downloading),
    .img_mounted   (img_mounted),
    .img_readonly  (img_readonly),
    .img_size_nz   (img_size_nz),
    .mbc_battery   (mbc_battery),
    .mbc2          (mbc2),
    .cart_ram_size (cart_ram_size),
    .cram_wr       (cram_wr),
    .osd_status    (osd_status),
    .autosave_en   (autosave_en),
    .load_req      (load_req),
    .save_req      (save_req),
    .bus           (bus),
    .busy          (busy),
    .loading       (loading)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Observes n cycles and reports whether any transfer activity was seen.
  task automatic watch_idle(input int n, output logic saw);
    saw = 1'b0;
    repeat (n) begin
      tick();
      if (busy || bus.sd_rd || bus.sd_wr) saw = 1'b1;
    end
  endtask

  task automatic push_sectors(input logic is_load, input int count);
    for (int i = 0; i < count; i++) sb.push_back({is_load, 8'(i)});
  endtask

  task automatic mount_image();
    downloading = 1'b1;
    tick();
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    tick();
  endtask

  // HPS model: serves up to max_sectors requests, stops when no request
  // appears within a bounded number of cycles.
  task automatic hps_serve(input int max_sectors, output int served);
    sector_t exp_sec;
    bk_exp_t exp_bk;
    int      wait_cnt;
    logic    stop;
    served = 0;
    stop   = 1'b0;
    while (served < max_sectors && !stop) begin
      wait_cnt = 0;
      while (!(bus.sd_rd || bus.sd_wr) && wait_cnt < 12) begin
        tick();
        wait_cnt++;
      end
      if (!(bus.sd_rd || bus.sd_wr)) begin
        stop = 1'b1;
      end else if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_request got lba=%0d rd=%0b wr=%0b, required no request",
                 bus.sd_lba, bus.sd_rd, bus.sd_wr);
        stop = 1'b1;
      end else begin
        exp_sec = sb.pop_front();
        if (bus.sd_rd) rd_pulses++;
        if (bus.sd_wr) wr_pulses++;

        checks++;
        if (bus.sd_lba !== {24'h0, exp_sec.lba})
          $display("[TB] FAIL sector_lba got=%0d exp=%0d", bus.sd_lba, exp_sec.lba);
        else passed++;

        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== (exp_sec.is_load ? 2'b10 : 2'b01))
          $display("[TB] FAIL sector_dir lba=%0d got rd/wr=%b%b exp load=%0b",
                   exp_sec.lba, bus.sd_rd, bus.sd_wr, exp_sec.is_load);
        else passed++;

        bus.sd_ack = 1'b1;
        tick();
        tick();
        tick();

        checks++;
        if ({busy, bus.sd_rd, bus.sd_wr} !== 3'b100)
          $display("[TB] FAIL req_drop lba=%0d got busy/rd/wr=%b%b%b exp=100",
                   exp_sec.lba, busy, bus.sd_rd, bus.sd_wr);
        else passed++;

        bus.sd_buff_wr = 1'b1;
        if (exp_sec.is_load) begin
          bus.sd_buff_addr = (exp_sec.lba == 8'd5) ? 8'h3C : (exp_sec.lba ^ 8'hA5);
          bus.sd_buff_dout = (exp_sec.lba == 8'd5) ? 16'hBEEF : {exp_sec.lba, ~exp_sec.lba};
          dq.push_back({1'b1, exp_sec.lba, bus.sd_buff_addr, bus.sd_buff_dout});
          #1;
          exp_bk = dq.pop_front();
          checks++;
          if ({bus.bk_wr, bus.bk_addr, bus.bk_data} !== {exp_bk.wr, exp_bk.addr, exp_bk.data})
            $display("[TB] FAIL load_path got wr=%0b addr=%h data=%h exp wr=%0b addr=%h data=%h",
                     bus.bk_wr, bus.bk_addr, bus.bk_data, exp_bk.wr, exp_bk.addr, exp_bk.data);
          else passed++;
        end else begin
          bus.bk_q = 16'($urandom);
          dq.push_back({1'b0, 16'h0000, bus.bk_q});
          #1;
          exp_bk = dq.pop_front();
          checks++;
          if ({bus.bk_wr, bus.sd_buff_din} !== {exp_bk.wr, exp_bk.data})
            $display("[TB] FAIL save_path got bk_wr=%0b din=%h exp bk_wr=%0b din=%h",
                     bus.bk_wr, bus.sd_buff_din, exp_bk.wr, exp_bk.data);
          else passed++;
        end

        tick();
        bus.sd_buff_wr = 1'b0;
        tick();
        bus.sd_ack = 1'b0;
        served++;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    logic saw;
    reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();

    checks++;
    if ({bus.sd_rd, bus.sd_wr, busy, loading} !== 4'b0000)
      $display("[TB] FAIL reset_flags got rd/wr/busy/loading=%b%b%b%b exp=0000",
               bus.sd_rd, bus.sd_wr, busy, loading);
    else passed++;

    checks++;
    if (bus.sd_lba !== 32'd0)
      $display("[TB] FAIL reset_lba got=%0d exp=0", bus.sd_lba);
    else passed++;

    load_req = 1'b1;
    watch_idle(8, saw);
    checks++;
    if (saw !== 1'b0)
      $display("[TB] FAIL reset_no_enable got activity=%0b exp=0", saw);
    else passed++;
    load_req = 1'b0;
    tick();
  endtask

  task automatic test_download_autoload();
    int served;
    mbc_battery   = 1'b1;
    cart_ram_size = 8'd2;
    mbc2          = 1'b0;
    img_size_nz   = 1'b1;
    mount_image();
    tick();
    push_sectors(1'b1, 16);
    rd_pulses = 0;
    wr_pulses = 0;
    downloading = 1'b0;
    hps_serve(256, served);
    tick();
    tick();

    checks++;
    if (served !== 16) $display("[TB] FAIL autoload_count got=%0d exp=16", served);
    else passed++;

    checks++;
    if ({rd_pulses, wr_pulses} !== {32'd16, 32'd0})
      $display("[TB] FAIL autoload_pulses got rd=%0d wr=%0d exp rd=16 wr=0", rd_pulses, wr_pulses);
    else passed++;

    checks++;
    if ({busy, loading, bus.sd_lba} !== {1'b0, 1'b1, 32'd15})
      $display("[TB] FAIL autoload_end got busy=%0b loading=%0b lba=%0d exp busy=0 loading=1 lba=15",
               busy, loading, bus.sd_lba);
    else passed++;
  endtask

  task automatic test_autosave();
    int   served;
    logic saw;
    mbc2          = 1'b1;
    cart_ram_size = 8'd0;
    autosave_en   = 1'b1;
    osd_status    = 1'b0;
    cram_wr = 1'b1;
    tick();
    cram_wr = 1'b0;
    watch_idle(5, saw);
    checks++;
    if (saw !== 1'b0) $display("[TB] FAIL autosave_osd_closed got activity=%0b exp=0", saw);
    else passed++;

    push_sectors(1'b0, 2);
    wr_pulses = 0;
    osd_status = 1'b1;
    hps_serve(256, served);
    tick();
    tick();

    checks++;
    if ({served, wr_pulses} !== {32'd2, 32'd2})
      $display("[TB] FAIL autosave_count got served=%0d wr=%0d exp 2/2", served, wr_pulses);
    else passed++;

    checks++;
    if ({busy, loading} !== 2'b00)
      $display("[TB] FAIL autosave_end got busy=%0b loading=%0b exp 0/0", busy, loading);
    else passed++;

    osd_status = 1'b0;
    tick();
    osd_status = 1'b1;
    watch_idle(10, saw);
    checks++;
    if (saw !== 1'b0) $display("[TB] FAIL autosave_pending_clear got activity=%0b exp=0", saw);
    else passed++;
    osd_status = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int   served;
    logic saw;
    push_sectors(1'b1, 2);
    load_req = 1'b1;
    save_req = 1'b1;
    tick();
    tick();
    save_req = 1'b0;
    tick();
    save_req = 1'b1;
    tick();
    hps_serve(256, served);
    checks++;
    if (served !== 2) $display("[TB] FAIL simul_count got=%0d exp=2", served);
    else passed++;

    watch_idle(10, saw);
    checks++;
    if (saw !== 1'b0) $display("[TB] FAIL busy_discard got activity=%0b exp=0", saw);
    else passed++;
    load_req = 1'b0;
    save_req = 1'b0;
    tick();
  endtask

  task automatic test_sizes();
    int served;
    mbc2          = 1'b0;
    cart_ram_size = 8'd1;
    push_sectors(1'b1, 4);
    load_req = 1'b1;
    hps_serve(256, served);
    checks++;
    if (served !== 4) $display("[TB] FAIL size1_count got=%0d exp=4", served);
    else passed++;
    load_req = 1'b0;

    cart_ram_size = 8'd3;
    push_sectors(1'b0, 64);
    save_req = 1'b1;
    hps_serve(256, served);
    tick();
    tick();
    checks++;
    if ({served, bus.sd_lba, busy, loading} !== {32'd64, 32'd63, 1'b0, 1'b0})
      $display("[TB] FAIL size3_save got served=%0d lba=%0d busy=%0b loading=%0b exp 64/63/0/0",
               served, bus.sd_lba, busy, loading);
    else passed++;
    save_req = 1'b0;
    tick();
  endtask

  task automatic test_readonly();
    logic saw;
    img_readonly = 1'b1;
    mount_image();
    downloading = 1'b0;
    watch_idle(10, saw);
    checks++;
    if (saw !== 1'b0) $display("[TB] FAIL ro_autoload got activity=%0b exp=0", saw);
    else passed++;

    save_req = 1'b1;
    watch_idle(10, saw);
    checks++;
    if (saw !== 1'b0) $display("[TB] FAIL ro_save got activity=%0b exp=0", saw);
    else passed++;
    save_req = 1'b0;

    load_req = 1'b1;
    watch_idle(10, saw);
    checks++;
    if (saw !== 1'b0) $display("[TB] FAIL ro_load got activity=%0b exp=0", saw);
    else passed++;
    load_req = 1'b0;
    img_readonly = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int   served;
    int   wait_cnt;
    logic saw;
    cart_ram_size = 8'd2;
    mbc2          = 1'b0;
    mount_image();
    push_sectors(1'b1, 16);
    downloading = 1'b0;
    hps_serve(7, served);
    checks++;
    if (served !== 7) $display("[TB] FAIL mid_prefix got=%0d exp=7", served);
    else passed++;

    wait_cnt = 0;
    while (!bus.sd_rd && wait_cnt < 12) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if ({bus.sd_rd, bus.sd_lba} !== {1'b1, 32'd7})
      $display("[TB] FAIL mid_lba7 got rd=%0b lba=%0d exp rd=1 lba=7", bus.sd_rd, bus.sd_lba);
    else passed++;

    bus.sd_ack = 1'b1;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.sd_rd, bus.sd_wr, busy, bus.sd_lba} !== {3'b000, 32'd0})
      $display("[TB] FAIL mid_reset got rd=%0b wr=%0b busy=%0b lba=%0d exp 0/0/0/0",
               bus.sd_rd, bus.sd_wr, busy, bus.sd_lba);
    else passed++;
    reset = 1'b0;
    bus.sd_ack = 1'b0;
    sb.delete();
    tick();

    load_req = 1'b1;
    watch_idle(10, saw);
    checks++;
    if (saw !== 1'b0) $display("[TB] FAIL mid_enable_cleared got activity=%0b exp=0", saw);
    else passed++;
    load_req = 1'b0;
    tick();
  endtask

  initial begin
    checks           = 0;
    passed           = 0;
    rd_pulses        = 0;
    wr_pulses        = 0;
    reset            = 1'b1;
    downloading      = 1'b0;
    img_mounted      = 1'b0;
    img_readonly     = 1'b0;
    img_size_nz      = 1'b0;
    mbc_battery      = 1'b0;
    mbc2             = 1'b0;
    cart_ram_size    = 8'd0;
    cram_wr          = 1'b0;
    osd_status       = 1'b0;
    autosave_en      = 1'b0;
    load_req         = 1'b0;
    save_req         = 1'b0;
    bus.sd_ack       = 1'b0;
    bus.sd_buff_addr = 8'd0;
    bus.sd_buff_wr   = 1'b0;
    bus.sd_buff_dout = 16'd0;
    bus.bk_q         = 16'd0;

    test_reset();
    test_download_autoload();
    test_autosave();
    test_back_to_back();
    test_sizes();
    test_readonly();
    test_reset_mid();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
